// File: rtl/alu_issue_stage_if.sv
// Decode-to-execute bundle interface for the ALU issue stage.
// The slave modport is the issue stage; the master modport is the decode/execute environment around it.
interface alu_issue_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic [31:0] in_imm;
  logic [4:0]  in_rd;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [3:0]  alu_control;
  logic [4:0]  rd;
  logic        illegal;
  logic        halted;
  logic [31:0] issue_count;

  modport slave (
    input  in_valid, in_opcode, in_funct3, in_funct7, in_rs1_data, in_rs2_data, in_imm, in_rd,
    input  out_ready,
    output in_ready, out_valid, rs1_data, rs2_data, alu_control, rd, illegal, halted, issue_count
  );

  modport master (
    output in_valid, in_opcode, in_funct3, in_funct7, in_rs1_data, in_rs2_data, in_imm, in_rd,
    output out_ready,
    input  in_ready, out_valid, rs1_data, rs2_data, alu_control, rd, illegal, halted, issue_count
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes opcode/funct fields into ALU control, conditions operands,
// and presents the bundle through a 2-entry skid buffer with a sticky halt on illegal ops.
module alu_issue_stage #(
  parameter int DEPTH = 2
) (
  input logic              clk,
  input logic              rst_n,
  input logic              flush,
  alu_issue_stage_if.slave bus
);

  if (DEPTH != 2) begin : g_depth_check
    $error("alu_issue_stage supports only DEPTH == 2");
  end

  localparam logic [3:0] CtlAnd  = 4'b0000;
  localparam logic [3:0] CtlOr   = 4'b0001;
  localparam logic [3:0] CtlAdd  = 4'b0010;
  localparam logic [3:0] CtlSll  = 4'b0011;
  localparam logic [3:0] CtlSub  = 4'b0100;
  localparam logic [3:0] CtlSrl  = 4'b0101;
  localparam logic [3:0] CtlMul  = 4'b0110;
  localparam logic [3:0] CtlXor  = 4'b0111;
  localparam logic [3:0] CtlSltu = 4'b1000;
  localparam logic [3:0] CtlIll  = 4'b1111;

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpLui   = 7'b0110111;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctl;
    logic [4:0]  rd;
    logic        ill;
  } entry_t;

  state_t      state_q, state_d;
  entry_t      head_q, head_d;
  entry_t      tail_q, tail_d;
  entry_t      dec;
  logic        in_ready_q, in_ready_d;
  logic        halted_q, halted_d;
  logic [31:0] count_q, count_d;
  logic        push, pop;

  logic [31:0] rs2Shamt;
  logic [31:0] immShamt;

  assign rs2Shamt = {27'b0, bus.in_rs2_data[4:0]};
  assign immShamt = {27'b0, bus.in_imm[4:0]};

  // Start from the illegal encoding (A=rs1, B=rs2) and override only on a recognised instruction.
  always_comb begin
    dec.a   = bus.in_rs1_data;
    dec.b   = bus.in_rs2_data;
    dec.ctl = CtlIll;
    dec.rd  = bus.in_rd;
    dec.ill = 1'b1;
    case (bus.in_opcode)
      OpR: begin
        if (bus.in_funct7 == 7'b0000000) begin
          case (bus.in_funct3)
            3'b000: begin dec.ctl = CtlAdd;  dec.ill = 1'b0; end
            3'b001: begin dec.ctl = CtlSll;  dec.b = rs2Shamt; dec.ill = 1'b0; end
            3'b011: begin dec.ctl = CtlSltu; dec.ill = 1'b0; end
            3'b100: begin dec.ctl = CtlXor;  dec.ill = 1'b0; end
            3'b101: begin dec.ctl = CtlSrl;  dec.b = rs2Shamt; dec.ill = 1'b0; end
            3'b110: begin dec.ctl = CtlOr;   dec.ill = 1'b0; end
            3'b111: begin dec.ctl = CtlAnd;  dec.ill = 1'b0; end
            default: ;
          endcase
        end else if (bus.in_funct7 == 7'b0100000 && bus.in_funct3 == 3'b000) begin
          dec.ctl = CtlSub;
          dec.ill = 1'b0;
        end else if (bus.in_funct7 == 7'b0000001 && bus.in_funct3 == 3'b000) begin
          dec.ctl = CtlMul;
          dec.ill = 1'b0;
        end
      end
      OpI: begin
        case (bus.in_funct3)
          3'b000: begin dec.ctl = CtlAdd;  dec.b = bus.in_imm; dec.ill = 1'b0; end
          3'b011: begin dec.ctl = CtlSltu; dec.b = bus.in_imm; dec.ill = 1'b0; end
          3'b100: begin dec.ctl = CtlXor;  dec.b = bus.in_imm; dec.ill = 1'b0; end
          3'b110: begin dec.ctl = CtlOr;   dec.b = bus.in_imm; dec.ill = 1'b0; end
          3'b111: begin dec.ctl = CtlAnd;  dec.b = bus.in_imm; dec.ill = 1'b0; end
          3'b001: begin
            if (bus.in_funct7 == 7'b0000000) begin
              dec.ctl = CtlSll;
              dec.b   = immShamt;
              dec.ill = 1'b0;
            end
          end
          3'b101: begin
            if (bus.in_funct7 == 7'b0000000) begin
              dec.ctl = CtlSrl;
              dec.b   = immShamt;
              dec.ill = 1'b0;
            end
          end
          default: ;
        endcase
      end
      OpLoad, OpStore: begin
        dec.ctl = CtlAdd;
        dec.b   = bus.in_imm;
        dec.ill = 1'b0;
      end
      OpLui: begin
        dec.ctl = CtlAdd;
        dec.a   = 32'b0;
        dec.b   = bus.in_imm;
        dec.ill = 1'b0;
      end
      default: ;
    endcase
  end

  assign push = bus.in_valid & in_ready_q;
  assign pop  = (state_q != EMPTY) & bus.out_ready;

  // The head entry always drives the outputs; the tail only fills when a push meets a stalled head.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            head_d  = dec;
            state_d = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_d = dec;
          end else if (push) begin
            tail_d  = dec;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_d  = tail_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // A pop swallowed by flush never reaches the ALU, so it neither counts nor halts.
  always_comb begin
    halted_d   = halted_q | (pop & head_q.ill & ~flush);
    count_d    = (pop && !flush) ? count_q + 32'd1 : count_q;
    in_ready_d = (state_d != FULL) & ~halted_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
      halted_q   <= 1'b0;
      count_q    <= 32'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
      halted_q   <= halted_d;
      count_q    <= count_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = (state_q != EMPTY);
  assign bus.rs1_data    = head_q.a;
  assign bus.rs2_data    = head_q.b;
  assign bus.alu_control = head_q.ctl;
  assign bus.rd          = head_q.rd;
  assign bus.illegal     = head_q.ill;
  assign bus.halted      = halted_q;
  assign bus.issue_count = count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed-vector bench for alu_issue_stage: decode, skid buffering, flush, halt and async reset.
module tb_alu_issue_stage;

  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpLui  = 7'b0110111;
  localparam logic [6:0] OpSys  = 7'b1110011;

  logic clk;
  logic rst_n;
  logic flush;
  int   checkCount;
  int   passCount;

  alu_issue_stage_if bus ();

  alu_issue_stage #(.DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp)
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    else
      passCount++;
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm, input logic [4:0] dst);
    bus.in_valid    = 1'b1;
    bus.in_opcode   = op;
    bus.in_funct3   = f3;
    bus.in_funct7   = f7;
    bus.in_rs1_data = a;
    bus.in_rs2_data = b;
    bus.in_imm      = imm;
    bus.in_rd       = dst;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    flush      = 1'b0;
    rst_n      = 1'b0;
    bus.out_ready = 1'b0;
    applyStimulus(7'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    bus.in_valid = 1'b0;
    #23;
    checkOutput("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("rst_alu", {28'b0, bus.alu_control}, 32'd0);
    checkOutput("rst_rs1", bus.rs1_data, 32'd0);
    checkOutput("rst_illegal", {31'b0, bus.illegal}, 32'd0);
    checkOutput("rst_halted", {31'b0, bus.halted}, 32'd0);
    checkOutput("rst_count", bus.issue_count, 32'd0);
    rst_n = 1'b1;

    // Streaming decode with out_ready held high: one bundle per cycle.
    bus.out_ready = 1'b1;
    applyStimulus(OpR, 3'b000, 7'b0000000, 32'd5, 32'd7, 32'd0, 5'd3);
    step();
    checkOutput("add_valid", {31'b0, bus.out_valid}, 32'd1);
    checkOutput("add_alu", {28'b0, bus.alu_control}, 32'h2);
    checkOutput("add_rs1", bus.rs1_data, 32'd5);
    checkOutput("add_rs2", bus.rs2_data, 32'd7);
    checkOutput("add_rd", {27'b0, bus.rd}, 32'd3);
    checkOutput("add_count0", bus.issue_count, 32'd0);
    applyStimulus(OpR, 3'b001, 7'b0000000, 32'd1, 32'h23, 32'd0, 5'd4);
    step();
    checkOutput("add_count1", bus.issue_count, 32'd1);
    checkOutput("sll_alu", {28'b0, bus.alu_control}, 32'h3);
    checkOutput("sll_rs2", bus.rs2_data, 32'h3);
    applyStimulus(OpI, 3'b001, 7'b0000000, 32'd1, 32'hABCD, 32'h404, 5'd5);
    step();
    checkOutput("slli_alu", {28'b0, bus.alu_control}, 32'h3);
    checkOutput("slli_rs2", bus.rs2_data, 32'h4);
    applyStimulus(OpLui, 3'b000, 7'b0000000, 32'hFFFFFFFF, 32'h55, 32'h12345000, 5'd6);
    step();
    checkOutput("lui_rs1", bus.rs1_data, 32'd0);
    checkOutput("lui_rs2", bus.rs2_data, 32'h12345000);
    checkOutput("lui_alu", {28'b0, bus.alu_control}, 32'h2);
    applyStimulus(OpR, 3'b000, 7'b0100000, 32'd10, 32'd3, 32'd0, 5'd7);
    step();
    checkOutput("sub_alu", {28'b0, bus.alu_control}, 32'h4);
    checkOutput("sub_illegal", {31'b0, bus.illegal}, 32'd0);
    applyStimulus(OpR, 3'b000, 7'b0000001, 32'd6, 32'd7, 32'd0, 5'd8);
    step();
    checkOutput("mul_alu", {28'b0, bus.alu_control}, 32'h6);
    bus.in_valid = 1'b0;
    step();
    checkOutput("drain_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("drain_count", bus.issue_count, 32'd6);

    // Back-pressure: third push must be refused while the first stays at the head.
    bus.out_ready = 1'b0;
    applyStimulus(OpI, 3'b000, 7'b0000000, 32'd10, 32'd99, 32'd1, 5'd1);
    step();
    checkOutput("bp_ready1", {31'b0, bus.in_ready}, 32'd1);
    applyStimulus(OpI, 3'b100, 7'b0000000, 32'hF0, 32'd99, 32'h0F, 5'd2);
    step();
    checkOutput("bp_ready2", {31'b0, bus.in_ready}, 32'd0);
    applyStimulus(OpI, 3'b110, 7'b0000000, 32'd1, 32'd99, 32'd2, 5'd3);
    step();
    checkOutput("bp_hold_rs1", bus.rs1_data, 32'd10);
    checkOutput("bp_hold_rs2", bus.rs2_data, 32'd1);
    checkOutput("bp_hold_alu", {28'b0, bus.alu_control}, 32'h2);
    checkOutput("bp_ready3", {31'b0, bus.in_ready}, 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    checkOutput("bp_second_alu", {28'b0, bus.alu_control}, 32'h7);
    checkOutput("bp_second_rs1", bus.rs1_data, 32'hF0);
    checkOutput("bp_second_rs2", bus.rs2_data, 32'h0F);
    checkOutput("bp_count7", bus.issue_count, 32'd7);
    checkOutput("bp_ready_back", {31'b0, bus.in_ready}, 32'd1);
    step();
    checkOutput("bp_empty", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("bp_count8", bus.issue_count, 32'd8);

    // Flush while FULL with pop and input valid asserted.
    bus.out_ready = 1'b0;
    applyStimulus(OpR, 3'b110, 7'b0000000, 32'd1, 32'd2, 32'd0, 5'd9);
    step();
    applyStimulus(OpR, 3'b111, 7'b0000000, 32'd3, 32'd4, 32'd0, 5'd10);
    step();
    checkOutput("fl_full_ready", {31'b0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("fl_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("fl_count", bus.issue_count, 32'd8);
    checkOutput("fl_ready", {31'b0, bus.in_ready}, 32'd1);

    // SLT is unsupported: seen at the head, then flushed without halting.
    bus.out_ready = 1'b0;
    applyStimulus(OpR, 3'b010, 7'b0000000, 32'd9, 32'd8, 32'h77, 5'd11);
    step();
    bus.in_valid = 1'b0;
    checkOutput("slt_illegal", {31'b0, bus.illegal}, 32'd1);
    checkOutput("slt_alu", {28'b0, bus.alu_control}, 32'hF);
    checkOutput("slt_rs1", bus.rs1_data, 32'd9);
    checkOutput("slt_rs2", bus.rs2_data, 32'd8);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("slt_fl_halted", {31'b0, bus.halted}, 32'd0);

    // Popping an illegal system opcode halts the stage until reset.
    applyStimulus(OpSys, 3'b000, 7'b0000000, 32'h11, 32'h22, 32'h33, 5'd12);
    step();
    bus.in_valid = 1'b0;
    checkOutput("sys_illegal", {31'b0, bus.illegal}, 32'd1);
    checkOutput("sys_alu", {28'b0, bus.alu_control}, 32'hF);
    checkOutput("sys_rs2", bus.rs2_data, 32'h22);
    bus.out_ready = 1'b1;
    step();
    checkOutput("halt_set", {31'b0, bus.halted}, 32'd1);
    checkOutput("halt_ready", {31'b0, bus.in_ready}, 32'd0);
    checkOutput("halt_count", bus.issue_count, 32'd9);
    applyStimulus(OpR, 3'b000, 7'b0000000, 32'd1, 32'd1, 32'd0, 5'd1);
    step();
    step();
    checkOutput("halt_ignore_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("halt_ignore_ready", {31'b0, bus.in_ready}, 32'd0);
    checkOutput("halt_ignore_count", bus.issue_count, 32'd9);

    // Reset clears halt; then an asynchronous reset between edges drops a held entry.
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    checkOutput("rerst_halted", {31'b0, bus.halted}, 32'd0);
    checkOutput("rerst_ready", {31'b0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b0;
    applyStimulus(OpR, 3'b100, 7'b0000000, 32'hAA, 32'h55, 32'd0, 5'd2);
    step();
    bus.in_valid = 1'b0;
    checkOutput("ar_pre_valid", {31'b0, bus.out_valid}, 32'd1);
    checkOutput("ar_pre_count", bus.issue_count, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("ar_rs1", bus.rs1_data, 32'd0);
    checkOutput("ar_ready", {31'b0, bus.in_ready}, 32'd1);
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Execute-side issue stage that produces the operand and control bundle consumed by the ALU. It accepts decoded instruction fields from the decode stage over a valid/ready handshake and translates opcode/funct3/funct7 into the 4-bit ALU control encoding. It selects and conditions operand B, then presents a registered bundle to the execute stage through a 2-entry skid buffer. It also detects unsupported instructions and raises a sticky `halted` flag.

## Interface
- `DEPTH`, 2: skid-buffer entries; fixed at 2, any other value is unsupported.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `flush` input 1: synchronous pipeline flush.
- `in_valid` input 1: decode bundle valid.
- `in_ready` output 1: stage can accept a bundle; registered.
- `in_opcode` input 7: instruction opcode.
- `in_funct3` input 3: funct3 field.
- `in_funct7` input 7: funct7 field.
- `in_rs1_data` input 32: register-file read of rs1.
- `in_rs2_data` input 32: register-file read of rs2.
- `in_imm` input 32: sign-extended immediate from decode.
- `in_rd` input 5: destination register.
- `out_valid` output 1: bundle valid toward the ALU.
- `out_ready` input 1: execute stage accepts the bundle.
- `rs1_data` output 32: ALU operand A.
- `rs2_data` output 32: ALU operand B, after selection.
- `alu_control` output 4: ALU operation code.
- `rd` output 5: destination register.
- `illegal` output 1: the current output bundle is unsupported.
- `halted` output 1: sticky; set once an illegal bundle has been handed off.
- `issue_count` output 32: number of bundles handed off, wrapping.

## Operation
- ALU control codes: AND 0000, OR 0001, ADD 0010, SUB 0100, SLTU 1000 (unsigned compare), SLL 0011, SRL 0101, MUL 0110, XOR 0111.
- R-type (0110011):
  - funct7 0000000 decodes funct3 as follows: 000 ADD, 001 SLL, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7 0100000 with funct3 000 is SUB.
  - funct7 0000001 with funct3 000 is MUL.
  - All other R-type combinations are illegal, including SLT and SRA.
  - Operand B is rs2, except for shifts, where B is {27'b0, rs2[4:0]}.
- I-type ALU (0010011): 000 ADDI, 011 SLTIU, 100 XORI, 110 ORI, 111 ANDI. B is imm.
  - SLLI (001) and SRLI (101) require funct7 0000000; B is {27'b0, imm[4:0]}.
  - Everything else in this opcode is illegal.
- Load (0000011) and store (0100011): ADD, B is imm.
- LUI (0110111): ADD, A forced to 0, B is imm.
- Any other opcode is illegal.
- Illegal bundles are still enqueued with `alu_control`=1111, A=rs1, B=rs2, `illegal`=1.
- Buffer states and transitions:
  - States are EMPTY, ONE and FULL. Transitions follow push = in_valid&in_ready and pop = out_valid&out_ready.
  - Push and pop together in ONE stays in ONE.
  - Pop in FULL goes to ONE.
  - Push in FULL is impossible because in_ready=0.
- Register-to-output relationships:
  - `in_ready` = (state != FULL) & !halted, registered.
  - `out_valid` = (state != EMPTY).
  - All outputs come from the head entry, and ordering is FIFO.
- `flush`:
  - The next state is EMPTY, and any same-cycle push or pop is discarded.
  - `issue_count` does not count a pop that coincides with flush.
  - `halted` is unaffected.
- `halted`:
  - Set on the pop of a bundle with `illegal`=1.
  - Once set, in_ready=0 until reset. Remaining entries still drain.
- `issue_count` increments on every pop and wraps from 0xFFFFFFFF to 0.

## Timing
- Reset values: state EMPTY, in_ready=1, out_valid=0, all data outputs 0, alu_control=0000, illegal=0, halted=0, issue_count=0.
- Latency: a bundle pushed at edge N is on the outputs with out_valid=1 after edge N.
- Throughput: one bundle per cycle when out_ready is held high.
- Stall stability: while out_valid=1 and out_ready=0, all output data is held stable.
- in_ready reacts one cycle late; the second entry absorbs the bundle accepted in that cycle.
- Asynchronous reset mid-operation drops all entries immediately.

## Test plan
- ADD x3,x1,x2 with rs1=5, rs2=7 and out_ready=1 -> one cycle later out_valid=1, alu_control=0010, rs1_data=5, rs2_data=7, issue_count goes from 0 to 1.
- SLL with rs2=0x00000023 and SLLI with imm=0x00000404 -> rs2_data=0x3 and 0x4 respectively, alu_control=0011.
- LUI with imm=0x12345000 and rs1=0xFFFFFFFF -> rs1_data=0, rs2_data=0x12345000, alu_control=0010.
- Hold out_ready=0 and push 3 back-to-back -> first two accepted, in_ready=0 thereafter, outputs hold the first bundle. Release -> bundles drain in order with no loss.
- Opcode 1110011 popped -> illegal=1, alu_control=1111, halted=1 next cycle, in_ready stays 0 and further pushes are ignored until rst_n is asserted low.
- flush asserted in FULL with a same-cycle push and pop -> EMPTY next cycle, out_valid=0, issue_count unchanged.
